// File: rtl/shifter_operand_sequencer.sv
// ARM addressing-mode-1 shifter operand sequencer, one shift step per cycle.
// Optional macro SHIFT_SEQ_DUALSTEP_EN: two steps per cycle while >= 2 remain.
module shifter_operand_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  imm_mode,
    input  logic [11:0]           instr,
    input  logic [DATA_WIDTH-1:0] rm_value,
    input  logic [7:0]            rs_value,
    input  logic                  carry_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  carry_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_LSL,
        OP_LSR,
        OP_ASR,
        OP_ROR,
        OP_RRX
    } op_e;

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] res_q, res_d;
    logic                  c_q, c_d;

    logic [DATA_WIDTH-1:0] ld_res;
    logic                  ld_c;
    logic [CNT_WIDTH-1:0]  ld_cnt;
    op_e                   ld_op;
    logic [4:0]            sh;
    logic [7:0]            amt;
    logic [DATA_WIDTH:0]   s1;
`ifdef SHIFT_SEQ_DUALSTEP_EN
    logic [DATA_WIDTH:0]   s2;
`endif

    assign sh  = instr[11:7];
    assign amt = rs_value;

    // Returns {carry, value} after a single one-bit step.
    function automatic logic [DATA_WIDTH:0] step(
        input op_e                   op,
        input logic [DATA_WIDTH-1:0] r,
        input logic                  c
    );
        logic [DATA_WIDTH:0] o;
        case (op)
            OP_LSL:  o = {r[DATA_WIDTH-1], r[DATA_WIDTH-2:0], 1'b0};
            OP_LSR:  o = {r[0], 1'b0, r[DATA_WIDTH-1:1]};
            OP_ASR:  o = {r[0], r[DATA_WIDTH-1], r[DATA_WIDTH-1:1]};
            OP_ROR:  o = {r[0], r[0], r[DATA_WIDTH-1:1]};
            default: o = {r[0], c, r[DATA_WIDTH-1:1]};
        endcase
        return o;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= OP_LSL;
            cnt_q   <= '0;
            res_q   <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_SHIFT;
            S_SHIFT: if (cnt_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ld_res = rm_value;
        ld_c   = carry_in;
        ld_cnt = '0;
        ld_op  = OP_LSL;
        if (imm_mode) begin
            ld_res = {{(DATA_WIDTH-8){1'b0}}, instr[7:0]};
            ld_cnt = CNT_WIDTH'({instr[11:8], 1'b0});
            ld_op  = OP_ROR;
        end else if (!instr[4]) begin
            ld_cnt = CNT_WIDTH'(sh);
            unique case (instr[6:5])
                2'b00: ld_op = OP_LSL;
                2'b01: begin
                    ld_op = OP_LSR;
                    if (sh == 5'd0) ld_cnt = CNT_WIDTH'(32);
                end
                2'b10: begin
                    ld_op = OP_ASR;
                    if (sh == 5'd0) ld_cnt = CNT_WIDTH'(32);
                end
                default: begin
                    if (sh == 5'd0) begin
                        ld_op  = OP_RRX;
                        ld_cnt = CNT_WIDTH'(1);
                    end else begin
                        ld_op  = OP_ROR;
                    end
                end
            endcase
        end else begin
            unique case (instr[6:5])
                2'b00: begin
                    ld_op  = OP_LSL;
                    ld_cnt = (amt > 8'd33) ? CNT_WIDTH'(33) : CNT_WIDTH'(amt);
                end
                2'b01: begin
                    ld_op  = OP_LSR;
                    ld_cnt = (amt > 8'd33) ? CNT_WIDTH'(33) : CNT_WIDTH'(amt);
                end
                2'b10: begin
                    ld_op  = OP_ASR;
                    ld_cnt = (amt > 8'd32) ? CNT_WIDTH'(32) : CNT_WIDTH'(amt);
                end
                default: begin
                    ld_op  = OP_ROR;
                    ld_cnt = CNT_WIDTH'(amt[4:0]);
                    // Rotate by a non-zero multiple of 32: value unchanged, C = bit 31
                    if (amt != 8'd0 && amt[4:0] == 5'd0)
                        ld_c = rm_value[DATA_WIDTH-1];
                end
            endcase
        end
    end

    always_comb begin
        res_d = res_q;
        c_d   = c_q;
        cnt_d = cnt_q;
        op_d  = op_q;
        s1    = step(op_q, res_q, c_q);
`ifdef SHIFT_SEQ_DUALSTEP_EN
        s2    = step(op_q, s1[DATA_WIDTH-1:0], s1[DATA_WIDTH]);
`endif
        if (state_q == S_IDLE && start) begin
            res_d = ld_res;
            c_d   = ld_c;
            cnt_d = ld_cnt;
            op_d  = ld_op;
        end else if (state_q == S_SHIFT && cnt_q != '0) begin
`ifdef SHIFT_SEQ_DUALSTEP_EN
            if (cnt_q >= CNT_WIDTH'(2)) begin
                {c_d, res_d} = s2;
                cnt_d        = cnt_q - CNT_WIDTH'(2);
            end else begin
                {c_d, res_d} = s1;
                cnt_d        = cnt_q - CNT_WIDTH'(1);
            end
`else
            {c_d, res_d} = s1;
            cnt_d        = cnt_q - CNT_WIDTH'(1);
`endif
        end
    end

    always_comb begin
        busy      = (state_q == S_SHIFT);
        done      = (state_q == S_DONE);
        result    = res_q;
        carry_out = c_q;
    end

endmodule

// File: tb/tb_shifter_operand_sequencer.sv
// Directed bench for shifter_operand_sequencer with an arithmetic ARM shifter model.
// Honours SHIFT_SEQ_DUALSTEP_EN when computing expected latency.
module tb_shifter_operand_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        imm_mode;
    logic [11:0] instr;
    logic [31:0] rm_value;
    logic [7:0]  rs_value;
    logic        carry_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    shifter_operand_sequencer #(
        .DATA_WIDTH(32),
        .CNT_WIDTH (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .imm_mode (imm_mode),
        .instr    (instr),
        .rm_value (rm_value),
        .rs_value (rs_value),
        .carry_in (carry_in),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry_out(carry_out)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ARM shifter operand semantics: returns {carry, value}
    function automatic logic [32:0] model(input logic imm, input logic [11:0] ins,
                                          input logic [31:0] rm, input logic [7:0] rs,
                                          input logic cin);
        logic [31:0]        v;
        logic signed [31:0] sr;
        int                 n;
        logic [1:0]         ty;
        ty = ins[6:5];
        if (imm) begin
            v = {24'd0, ins[7:0]};
            n = 2 * int'(ins[11:8]);
            if (n == 0) return {cin, v};
            v = (v >> n) | (v << (32 - n));
            return {v[31], v};
        end
        if (!ins[4]) begin
            n = int'(ins[11:7]);
            if (n == 0) begin
                case (ty)
                    2'd0:    return {cin, rm};
                    2'd1:    return {rm[31], 32'd0};
                    2'd2:    return {rm[31], {32{rm[31]}}};
                    default: return {rm[0], cin, rm[31:1]};
                endcase
            end
        end else begin
            n = int'(rs);
            if (n == 0) return {cin, rm};
        end
        case (ty)
            2'd0: begin
                if (n < 32) return {rm[32-n], rm << n};
                if (n == 32) return {rm[0], 32'd0};
                return 33'd0;
            end
            2'd1: begin
                if (n < 32) return {rm[n-1], rm >> n};
                if (n == 32) return {rm[31], 32'd0};
                return 33'd0;
            end
            2'd2: begin
                if (n < 32) begin
                    sr = $signed(rm) >>> n;
                    return {rm[n-1], sr};
                end
                return {rm[31], {32{rm[31]}}};
            end
            default: begin
                n = n % 32;
                if (n == 0) return {rm[31], rm};
                v = (rm >> n) | (rm << (32 - n));
                return {rm[n-1], v};
            end
        endcase
    endfunction

    function automatic int steps(input logic imm, input logic [11:0] ins,
                                 input logic [7:0] rs);
        int n;
        if (imm) return 2 * int'(ins[11:8]);
        if (!ins[4]) begin
            n = int'(ins[11:7]);
            case (ins[6:5])
                2'd0:    return n;
                2'd1:    return (n == 0) ? 32 : n;
                2'd2:    return (n == 0) ? 32 : n;
                default: return (n == 0) ? 1 : n;
            endcase
        end
        n = int'(rs);
        case (ins[6:5])
            2'd0:    return (n > 33) ? 33 : n;
            2'd1:    return (n > 33) ? 33 : n;
            2'd2:    return (n > 32) ? 32 : n;
            default: return int'(rs[4:0]);
        endcase
    endfunction

    function automatic int latency(input int cnt);
`ifdef SHIFT_SEQ_DUALSTEP_EN
        return (cnt + 1) / 2 + 1;
`else
        return cnt + 1;
`endif
    endfunction

    // Drive one operation; check busy/done each cycle and the operand at done.
    // poke_edge > 0 pulses start with junk operands so that edge samples it.
    task automatic run(input string name, input logic imm, input logic [11:0] ins,
                       input logic [31:0] rm, input logic [7:0] rs, input logic cin,
                       input int poke_edge);
        logic [32:0] e;
        int          l;
        e = model(imm, ins, rm, rs, cin);
        l = latency(steps(imm, ins, rs));
        @(negedge clk);
        imm_mode = imm;
        instr    = ins;
        rm_value = rm;
        rs_value = rs;
        carry_in = cin;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        imm_mode = ~imm;
        instr    = ~ins;
        rm_value = ~rm;
        rs_value = ~rs;
        carry_in = ~cin;
        for (int n = 0; n <= l; n++) begin
            if (n > 0) @(negedge clk);
            start = (poke_edge > 0 && n == poke_edge - 1);
            chk1({name, " busy"}, busy, n < l);
            chk1({name, " done"}, done, n == l);
        end
        start = 1'b0;
        chk32({name, " result"}, result, e[31:0]);
        chk1({name, " carry"}, carry_out, e[32]);
        @(negedge clk);
        chk1({name, " done drop"}, done, 1'b0);
        chk1({name, " idle"}, busy, 1'b0);
        chk32({name, " hold"}, result, e[31:0]);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        imm_mode = 1'b0;
        instr    = '0;
        rm_value = '0;
        rs_value = '0;
        carry_in = 1'b0;
        repeat (2) @(negedge clk);
        chk1("reset busy", busy, 1'b0);
        chk1("reset done", done, 1'b0);
        chk32("reset result", result, 32'd0);
        chk1("reset carry", carry_out, 1'b0);
        reset = 1'b0;

        run("imm4FF", 1'b1, 12'h4FF, 32'h0, 8'h0, 1'b0, 0);
        chk32("imm4FF lit", result, 32'hFF000000);
        chk1("imm4FF lit c", carry_out, 1'b1);

        run("imm0AB", 1'b1, 12'h0AB, 32'h0, 8'h0, 1'b1, 0);
        chk32("imm0AB lit", result, 32'h000000AB);
        chk1("imm0AB lit c", carry_out, 1'b1);

        run("lsr0", 1'b0, 12'h020, 32'h80000001, 8'h0, 1'b0, 0);
        chk32("lsr0 lit", result, 32'h0);
        chk1("lsr0 lit c", carry_out, 1'b1);

        run("asr0", 1'b0, 12'h040, 32'h80000001, 8'h0, 1'b0, 0);
        chk32("asr0 lit", result, 32'hFFFFFFFF);
        chk1("asr0 lit c", carry_out, 1'b1);

        run("lslrs40", 1'b0, 12'h010, 32'hFFFFFFFF, 8'd40, 1'b1, 0);
        chk32("lslrs40 lit", result, 32'h0);
        chk1("lslrs40 lit c", carry_out, 1'b0);

        run("lslrs32", 1'b0, 12'h010, 32'hFFFFFFFF, 8'd32, 1'b0, 0);
        chk32("lslrs32 lit", result, 32'h0);
        chk1("lslrs32 lit c", carry_out, 1'b1);

        run("lslrs0", 1'b0, 12'h010, 32'hFFFFFFFF, 8'd0, 1'b0, 0);
        chk32("lslrs0 lit", result, 32'hFFFFFFFF);
        chk1("lslrs0 lit c", carry_out, 1'b0);

        run("rrx", 1'b0, 12'h060, 32'h00000003, 8'h0, 1'b1, 0);
        chk32("rrx lit", result, 32'h80000001);
        chk1("rrx lit c", carry_out, 1'b1);

        run("rorrs32", 1'b0, 12'h070, 32'h80000000, 8'h20, 1'b0, 0);
        chk32("rorrs32 lit", result, 32'h80000000);
        chk1("rorrs32 lit c", carry_out, 1'b1);

        run("lsl4", 1'b0, 12'h200, 32'hF000000F, 8'h0, 1'b0, 0);
        run("imm13F", 1'b1, 12'h13F, 32'h0, 8'h0, 1'b0, 0);
        run("asrrs40", 1'b0, 12'h050, 32'h80000000, 8'd40, 1'b0, 0);
        run("lsrrs4", 1'b0, 12'h030, 32'h000000F8, 8'd4, 1'b0, 0);
        run("lsrrs33", 1'b0, 12'h030, 32'hFFFFFFFF, 8'd33, 1'b1, 0);
        run("lsrrs32", 1'b0, 12'h030, 32'h80000000, 8'd32, 1'b0, 0);
        run("asr7", 1'b0, 12'h3C0, 32'h8000F000, 8'h0, 1'b0, 0);
        run("rorrs37", 1'b0, 12'h070, 32'h0000001F, 8'd37, 1'b0, 0);

        run("ror16 poke", 1'b0, 12'h860, 32'h1234ABCD, 8'h0, 1'b0, 3);
        chk32("ror16 lit", result, 32'hABCD1234);
        chk1("ror16 lit c", carry_out, 1'b1);

        @(negedge clk);
        imm_mode = 1'b0;
        instr    = 12'h860;
        rm_value = 32'h1234ABCD;
        rs_value = 8'h0;
        carry_in = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk1("midrst busy before", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk1("midrst busy", busy, 1'b0);
        chk1("midrst done", done, 1'b0);
        chk32("midrst result", result, 32'h0);
        chk1("midrst carry", carry_out, 1'b0);

        run("after rst", 1'b0, 12'h860, 32'h1234ABCD, 8'h0, 1'b0, 0);
        chk32("after rst lit", result, 32'hABCD1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shifter_operand_sequencer.md
Name: shifter_operand_sequencer

Overview:
Multi-cycle controller that evaluates the ARM data-processing shifter operand (addressing mode 1) and its shifter carry-out with a 1-bit-per-cycle shift/rotate datapath. It covers all three forms: 32-bit rotated immediate, immediate shift, and register shift. It sits between decode/register-file read and the ALU, and handshakes with the control unit through start/busy/done.

Parameters:
DATA_WIDTH, 32, operand width; only 32 is supported.
CNT_WIDTH, 6, width of the remaining-shift counter; must hold 0..33.

Ports:
clk  input  1  system clock; all state changes on the rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
imm_mode  input  1  I bit: 1 = rotated immediate, 0 = register forms
instr  input  12  instruction bits [11:0]
rm_value  input  32  Rm contents
rs_value  input  8  Rs[7:0] contents, used for register shifts
carry_in  input  1  current CPSR C flag
busy  output  1  high from the accept edge until done is asserted
done  output  1  one-cycle pulse; result and carry_out are valid
result  output  32  shifter_operand
carry_out  output  1  shifter_carry_out

Behaviour:
- Reset: state IDLE, busy=0, done=0, result=0, carry_out=0, counter=0. Reset overrides all other activity, including a reset asserted mid-SHIFT; any partial result is discarded.
- States:
  - IDLE: start=1 → load, then go to SHIFT.
  - SHIFT: counter>0 → one step, counter−1. counter==0 → go to DONE.
  - DONE: done=1 for one cycle, then go to IDLE.
- start is ignored while busy=1 or while in DONE. result and carry_out hold their values until the next accepted start.
- Latency: start accepted at edge E0 → done high in the cycle after edge E(count+1).
- Load values (result register ← source, carry register ← initial C):
  - Immediate form: source = zero-extended instr[7:0]; count = 2·instr[11:8]; C = carry_in.
  - Immediate shift (instr[4]=0): shift_imm = instr[11:7], type = instr[6:5], source = rm_value, C = carry_in.
    - LSL: count = shift_imm.
    - LSR or ASR with shift_imm=0: count = 32.
    - ROR with shift_imm≠0: count = shift_imm.
    - ROR with shift_imm=0 (RRX): count = 1, one RRX step.
  - Register shift (instr[4]=1): amt = rs_value[7:0], source = rm_value, C = carry_in.
    - LSL or LSR: count = min(amt, 33).
    - ASR: count = min(amt, 32).
    - ROR with amt=0: count = 0.
    - ROR with amt≠0 and amt[4:0]=0: count = 0 and C ← rm_value[31].
    - ROR otherwise: count = amt[4:0].
- One step, where r is the result register:
  - LSL: C ← r[31]; r ← {r[30:0], 0}.
  - LSR: C ← r[0]; r ← {0, r[31:1]}.
  - ASR: C ← r[0]; r ← {r[31], r[31:1]}.
  - ROR: C ← r[0]; r ← {r[0], r[31:1]}.
  - RRX: r ← {C_old, r[31:1]}; C ← r_old[0].
- Required boundary results (the step rules above produce these):
  - Immediate with rotate 0 → carry_in passes through.
  - LSL/LSR by 32 → result 0; carry = Rm[0] (LSL) or Rm[31] (LSR).
  - LSL/LSR by more than 32 → result 0, carry 0.
  - ASR by 32 or more → result all Rm[31], carry Rm[31].
- Inputs are sampled only at the accept edge. Later changes to the inputs do not affect an operation in flight.

Optional Feature:
SHIFT_SEQ_DUALSTEP_EN:
- Defined: SHIFT consumes 2 steps per cycle while counter≥2, and 1 step when counter=1. carry = the last bit moved out. Latency = ceil(count/2)+1 edges to done.
- Undefined: 1 step per cycle exactly as above.
- result and carry_out are identical in both builds.

Test Plan:
- imm_mode=1, instr=12'h4FF, carry_in=0 → result=32'hFF000000, carry_out=1, done after edge E9; busy=1 from E0 through E8.
- imm_mode=1, instr=12'h0AB, carry_in=1 → result=32'h000000AB, carry_out=1, done after E1.
- imm_mode=0, instr=12'h020 (LSR #0), rm=32'h80000001 → result=0, carry_out=1, 32 steps. Repeat with instr=12'h040 (ASR #0) → result=32'hFFFFFFFF, carry_out=1.
- imm_mode=0, instr=12'h010 (LSL by Rs), rm=32'hFFFFFFFF:
  - rs=40 → result=0, carry_out=0.
  - rs=32 → result=0, carry_out=1.
  - rs=0, carry_in=0 → result=32'hFFFFFFFF, carry_out=0, done after E1.
- imm_mode=0, instr=12'h060 (RRX), rm=32'h00000003, carry_in=1 → result=32'h80000001, carry_out=1, done after E2. Then instr=12'h070 (ROR by Rs) with rs=8'h20, rm=32'h80000000 → result unchanged, carry_out=1.
- Start a ROR-by-16 operation, then:
  - pulse start with different operands at E3 → ignored; original result is produced.
  - restart and assert reset at E5 → next cycle busy=0, done=0, result=0, carry_out=0.
  - a new start after reset completes normally.
